// File: rtl/mac_array_horner_ctrl_pkg.sv
// rtl/mac_array_horner_ctrl_pkg.sv - shared constants, FSM states and lane slicing for the Horner MAC sequencer
package gf_mac_pkg;

    localparam int NLANES = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // LSB of lane 'lane' inside a flat NLANES*width bus
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mac_array_horner_ctrl_if.sv
// rtl/mac_array_horner_ctrl_if.sv - operand and result buses between the Horner sequencer and the 9-lane GF MAC array
interface mac_array_horner_ctrl_if #(
    parameter int M = 16
);
    import gf_mac_pkg::*;

    logic [NLANES*M-1:0] mac_multiplicand;
    logic [NLANES*M-1:0] mac_multiplier;
    logic [NLANES*M-1:0] mac_adder;
    logic [NLANES*M-1:0] mac_result;

    modport master (
        output mac_multiplicand,
        output mac_multiplier,
        output mac_adder,
        input  mac_result
    );

    modport slave (
        input  mac_multiplicand,
        input  mac_multiplier,
        input  mac_adder,
        output mac_result
    );

endinterface

// File: rtl/mac_array_horner_ctrl_lane.sv
// rtl/mac_array_horner_ctrl_lane.sv - one Horner lane: point, accumulator, operand registers, result capture (ZERO_FLAG_EN adds zero flag)
module mac_horner_lane #(
    parameter int m = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pt_we,
    input  logic [m-1:0] pt_data,
    input  logic         clr_acc,
    input  logic         issue,
    input  logic         capture,
    input  logic         final_step,
    input  logic [m-1:0] result,
    output logic [m-1:0] multiplicand,
    output logic [m-1:0] multiplier,
    output logic [m-1:0] eval_out
`ifdef ZERO_FLAG_EN
    ,
    output logic         zero_flag
`endif
);

    logic [m-1:0] point;
    logic [m-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            point        <= '0;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            eval_out     <= '0;
        end else begin
            if (pt_we) begin
                point <= pt_data;
            end
            if (clr_acc) begin
                acc <= '0;
            end else if (capture) begin
                acc <= result;
            end
            if (issue) begin
                multiplicand <= acc;
                multiplier   <= point;
            end
            // The final result is taken straight off the array so eval_out is valid in the DONE cycle
            if (final_step) begin
                eval_out <= result;
            end
        end
    end

`ifdef ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else if (final_step) begin
            zero_flag <= (result == '0);
        end
    end
`endif

endmodule

// File: rtl/mac_array_horner_ctrl.sv
// rtl/mac_array_horner_ctrl.sv - Horner-rule sequencer for the 9-lane GF(2^m) MAC array; ZERO_FLAG_EN adds zero_mask output
module mac_array_horner_ctrl
    import gf_mac_pkg::*;
#(
    parameter int m       = 16,
    parameter int DEG_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pt_we,
    input  logic [3:0]             pt_idx,
    input  logic [m-1:0]           pt_data,
    input  logic                   start,
    input  logic [DEG_W-1:0]       degree,
    output logic                   coef_req,
    input  logic                   coef_valid,
    input  logic [m-1:0]           coef_data,
    mac_array_horner_ctrl_if.master mac,
    output logic                   busy,
    output logic                   done,
    output logic [NLANES*m-1:0]    eval_out
`ifdef ZERO_FLAG_EN
    ,
    output logic [NLANES-1:0]      zero_mask
`endif
);

    localparam int WCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t           state;
    state_t           state_nx;
    logic [DEG_W-1:0] coef_cnt;
    logic [WCW-1:0]   wait_cnt;
    logic [m-1:0]     coef_reg;
    logic             accept_start;
    logic             issue_fire;
    logic             wait_last;
    logic             final_step;
    logic             pt_wr_en;

    assign accept_start = (state == IDLE) && start;
    assign issue_fire   = (state == ISSUE) && coef_valid;
    assign wait_last    = (state == WAIT) && (wait_cnt == '0);
    assign final_step   = wait_last && (coef_cnt == '0);
    // Points are frozen while a run is active; indices past the last lane are dropped
    assign pt_wr_en     = pt_we && (state == IDLE) && (pt_idx < 4'(NLANES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        coef_req = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                coef_req = 1'b1;
                if (coef_valid) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = (coef_cnt == '0) ? DONE : ISSUE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // coef_cnt counts coefficients still to issue after the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_cnt <= '0;
            wait_cnt <= '0;
            coef_reg <= '0;
        end else begin
            if (accept_start) begin
                coef_cnt <= degree;
            end else if (wait_last && (coef_cnt != '0)) begin
                coef_cnt <= coef_cnt - 1'b1;
            end
            if (issue_fire) begin
                coef_reg <= coef_data;
                wait_cnt <= WCW'(MAC_LAT - 1);
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    assign mac.mac_adder = {NLANES{coef_reg}};

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        mac_horner_lane #(
            .m(m)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .pt_we        (pt_wr_en && (pt_idx == 4'(i))),
            .pt_data      (pt_data),
            .clr_acc      (accept_start),
            .issue        (issue_fire),
            .capture      (wait_last),
            .final_step   (final_step),
            .result       (mac.mac_result[lane_lsb(i, m) +: m]),
            .multiplicand (mac.mac_multiplicand[lane_lsb(i, m) +: m]),
            .multiplier   (mac.mac_multiplier[lane_lsb(i, m) +: m]),
            .eval_out     (eval_out[lane_lsb(i, m) +: m])
`ifdef ZERO_FLAG_EN
            ,
            .zero_flag    (zero_mask[i])
`endif
        );
    end

endmodule
